// File: rtl/nn_pkg.sv
// Shared constants for the conv datapath: widths, fixed-point scaling,
// controller state encoding and output saturation bounds.
package nn_pkg;

  localparam int DATSIZE = 22;
  localparam int PARSIZE = 16;
  localparam int FPSHIFT = 14;
  localparam int ACC_W   = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = (48'sd1 <<< (DATSIZE - 1)) - 48'sd1;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(48'sd1 <<< (DATSIZE - 1));

endpackage

// File: rtl/conv_dot9.sv
// Nine-tap signed dot product: registered products, then a registered adder
// tree. Two-cycle latency, tracked by a valid shift register driven by i_en.
module conv_dot9
  import nn_pkg::*;
#(
  parameter int DAT_W = DATSIZE,
  parameter int PAR_W = PARSIZE,
  localparam int PROD_W = DAT_W + PAR_W,
  localparam int SUM_W  = PROD_W + 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic [9*DAT_W-1:0]      i_window,
  input  logic [9*PAR_W-1:0]      i_weights,
  output logic signed [SUM_W-1:0] o_sum,
  output logic                    o_valid
);

  logic signed [PROD_W-1:0] w_prod [9];
  logic signed [PROD_W-1:0] r_prod [9];
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  r_sum;
  logic [1:0]               r_vld;

  // NOTE: every variable written in always_comb gets a value before any branch
  // or loop, so no path can leave it holding its old value (no latch).
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < 9; k++) begin
      w_prod[k] = PROD_W'($signed(i_weights[k*PAR_W +: PAR_W]))
                * PROD_W'($signed(i_window[k*DAT_W +: DAT_W]));
      w_sum     = w_sum + SUM_W'(r_prod[k]);
    end
  end

  // NOTE: the product registers are reset like any other pipeline stage, so a
  // reset leaves no stale partial products behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) r_prod[k] <= '0;
      r_sum <= '0;
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[0], i_en};
      if (i_en)     r_prod <= w_prod;
      if (r_vld[0]) r_sum  <= w_sum;
    end
  end

  assign o_sum   = r_sum;
  assign o_valid = r_vld[1];

endmodule

// File: rtl/conv_mac_unit.sv
// One output pixel of a 3x3 conv: accumulate n_ch window/kernel beats, add bias,
// rescale, ReLU, saturate. Define CONV_MAC_ROUND_EN for round-half-up rescaling.
module conv_mac_unit
  import nn_pkg::*;
#(
  parameter int DAT_W    = DATSIZE,
  parameter int PAR_W    = PARSIZE,
  parameter int FP_SHIFT = FPSHIFT,
  parameter int ACC_W    = nn_pkg::ACC_W,
  parameter int RELU     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [6:0]         n_ch,
  input  logic [PAR_W-1:0]   bias,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [9*DAT_W-1:0] window,
  input  logic [9*PAR_W-1:0] weights,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DAT_W-1:0]   out_data,
  output logic               busy
);

  localparam int SUM_W = DAT_W + PAR_W + 4;

  state_t                   r_state, w_state_nx;
  logic [6:0]               r_n_ch, r_cnt;
  logic signed [PAR_W-1:0]  r_bias;
  logic signed [ACC_W-1:0]  r_acc;
  logic [1:0]               r_drain;
  logic [DAT_W-1:0]         r_out_data;

  logic                     w_start_ok, w_take, w_last_beat, w_drain_done;
  logic signed [SUM_W-1:0]  w_sum;
  logic                     w_sum_vld;
  logic signed [ACC_W-1:0]  w_biased, w_scaled, w_relu;
  logic [DAT_W-1:0]         w_clip;

  assign w_start_ok   = (r_state == IDLE) && start && (n_ch != '0);
  assign w_take       = (r_state == ACCUM) && in_valid;
  assign w_last_beat  = w_take && (r_cnt == r_n_ch - 7'd1);
  assign w_drain_done = (r_state == DRAIN) && (r_drain == 2'd2);

  conv_dot9 #(.DAT_W(DAT_W), .PAR_W(PAR_W)) u_dot9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_take),
    .i_window  (window),
    .i_weights (weights),
    .o_sum     (w_sum),
    .o_valid   (w_sum_vld)
  );

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_start_ok) w_state_nx = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (w_last_beat) w_state_nx = DRAIN;
      end
      DRAIN: if (w_drain_done) w_state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Bias is aligned to the accumulator's 2*FP_SHIFT fraction before the rescale.
  always_comb begin
    w_biased = r_acc + (ACC_W'(r_bias) <<< FP_SHIFT);
`ifdef CONV_MAC_ROUND_EN
    w_biased = w_biased + (ACC_W'(1) <<< (FP_SHIFT - 1));
`endif
    w_scaled = w_biased >>> FP_SHIFT;
    w_relu   = ((RELU != 0) && (w_scaled < 0)) ? '0 : w_scaled;
    if (w_relu > ACC_W'(SAT_MAX))      w_clip = SAT_MAX[DAT_W-1:0];
    else if (w_relu < ACC_W'(SAT_MIN)) w_clip = SAT_MIN[DAT_W-1:0];
    else                               w_clip = w_relu[DAT_W-1:0];
  end

  // NOTE: state is only ever updated with non-blocking assignments, so every
  // always_ff block sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_n_ch     <= '0;
      r_cnt      <= '0;
      r_bias     <= '0;
      r_acc      <= '0;
      r_drain    <= '0;
      r_out_data <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_start_ok) begin
        r_n_ch <= n_ch;
        r_bias <= bias;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_sum_vld) r_acc <= r_acc + ACC_W'(w_sum);
        if (w_take)    r_cnt <= r_cnt + 7'd1;
      end
      r_drain <= ((r_state == DRAIN) && !w_drain_done) ? r_drain + 2'd1 : 2'd0;
      if (w_drain_done) r_out_data <= w_clip;
    end
  end

  assign out_data = r_out_data;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Bench for conv_mac_unit: a RELU=1 and a RELU=0 instance share all inputs;
// directed table vectors, random pixels against an arithmetic model, reset mid-op.
module tb_conv_mac_unit;

  localparam int DW = 22;
  localparam int PW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [6:0]        n_ch = '0;
  logic [PW-1:0]     bias = '0;
  logic              in_valid = 1'b0;
  logic [9*DW-1:0]   window = '0;
  logic [9*PW-1:0]   weights = '0;
  logic              out_ready = 1'b0;

  logic              in_ready1, out_valid1, busy1;
  logic              in_ready0, out_valid0, busy0;
  logic [DW-1:0]     out_data1, out_data0;

  always #5 clk = ~clk;

  conv_mac_unit #(.RELU(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_ch(n_ch), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready1), .window(window), .weights(weights),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
  );

  conv_mac_unit #(.RELU(0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .start(start), .n_ch(n_ch), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready0), .window(window), .weights(weights),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [9*DW-1:0] g_win [64];
  logic [9*PW-1:0] g_wts [64];

  typedef struct {
    int           n;
    bit           tap0_only;
    logic [DW-1:0] x;
    logic [PW-1:0] w;
    logic [PW-1:0] b;
    int           hold;
    longint       exp1;
    longint       exp0;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Real-number rules scaled by 2^14: sum of products, plus bias, divided by
  // 2^14 with floor (or half-up), then ReLU and clamp to 22-bit signed.
  function automatic longint model(input int n, input logic signed [PW-1:0] b, input bit relu);
    longint acc = 0;
    longint r;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 9; k++)
        acc += longint'($signed(g_wts[i][k*PW +: PW])) * longint'($signed(g_win[i][k*DW +: DW]));
    acc += longint'(b) * 16384;
`ifdef CONV_MAC_ROUND_EN
    acc += 8192;
`endif
    r = acc >>> 14;
    if (relu && r < 0) r = 0;
    if (r > 2097151)  r = 2097151;
    if (r < -2097152) r = -2097152;
    return r;
  endfunction

  task automatic fill_uniform(input int n, input bit tap0_only, input logic [DW-1:0] x, input logic [PW-1:0] w);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 9; k++) begin
        g_win[i][k*DW +: DW] = (tap0_only && k != 0) ? '0 : x;
        g_wts[i][k*PW +: PW] = (tap0_only && k != 0) ? '0 : w;
      end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready1,  0);
    check({tag, "_out_valid"}, out_valid1, 0);
    check({tag, "_busy"},      busy1,      0);
    check({tag, "_out_data"},  out_data1,  0);
    check({tag, "_out_data_nr"}, out_data0, 0);
  endtask

  task automatic run_pixel(input int n, input logic [PW-1:0] b, input bit gaps, input int hold,
                           output longint res1, output longint res0);
    int  i = 0;
    int  cyc = 0;
    int  lat = 1;
    bit  take;
    @(negedge clk);
    start = 1'b1; n_ch = n[6:0]; bias = b;
    @(negedge clk);
    start = 1'b0;
    while (i < n && cyc < 4000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      window   = g_win[i];
      weights  = g_wts[i];
      take     = in_valid && in_ready1;
      @(negedge clk);
      cyc++;
      if (take) i++;
    end
    in_valid = 1'b0;
    if (i < n) check("beat_budget", i, n);
    check("in_ready_after_last", in_ready1, 0);
    while (!out_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    check("out_valid_nr", out_valid0, 1);
    res1 = $signed(out_data1);
    res0 = $signed(out_data0);
    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      n_ch  = 7'd1;
      @(negedge clk);
      start = 1'b0;
      check("hold_out_valid", out_valid1, 1);
      check("hold_out_data",  $signed(out_data1), res1);
      check("hold_in_ready",  in_ready1, 0);
      check("hold_busy",      busy1, 1);
    end
    out_ready = 1'b1;
    start = 1'b1;
    n_ch  = 7'd1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("post_hs_out_valid", out_valid1, 0);
    check("post_hs_busy", busy1, 0);
    @(negedge clk);
    check("start_at_hs_ignored", busy1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint r1, r0, e1, e0;
    int     takes, stray;

    tbl[0] = '{n: 1,  tap0_only: 0, x: 22'd16384,   w: 16'd16384, b: 16'd0,    hold: 0, exp1: 147456,  exp0: 147456};
    tbl[1] = '{n: 1,  tap0_only: 0, x: 22'd16384,   w: 16'hC000,  b: 16'd8192, hold: 0, exp1: 0,       exp0: -139264};
    tbl[2] = '{n: 64, tap0_only: 0, x: 22'd1048576, w: 16'd16384, b: 16'd0,    hold: 5, exp1: 2097151, exp0: 2097151};
`ifdef CONV_MAC_ROUND_EN
    tbl[3] = '{n: 1,  tap0_only: 1, x: 22'd1,       w: 16'd8192,  b: 16'd0,    hold: 0, exp1: 1,       exp0: 1};
`else
    tbl[3] = '{n: 1,  tap0_only: 1, x: 22'd1,       w: 16'd8192,  b: 16'd0,    hold: 0, exp1: 0,       exp0: 0};
`endif
    tbl[4] = '{n: 64, tap0_only: 0, x: 22'd1048576, w: 16'hC000,  b: 16'd0,    hold: 0, exp1: 0,       exp0: -2097152};
    tbl[5] = '{n: 3,  tap0_only: 0, x: 22'd8192,    w: 16'hE000,  b: 16'h7FFF, hold: 2, exp1: 0,       exp0: -77825};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    @(negedge clk);
    start = 1'b1; n_ch = 7'd0;
    @(negedge clk);
    start = 1'b0;
    check("zero_nch_ignored", busy1, 0);

    for (int v = 0; v < 6; v++) begin
      fill_uniform(tbl[v].n, tbl[v].tap0_only, tbl[v].x, tbl[v].w);
      run_pixel(tbl[v].n, tbl[v].b, 1'b0, tbl[v].hold, r1, r0);
      check($sformatf("vec%0d_relu", v),   r1, tbl[v].exp1);
      check($sformatf("vec%0d_norelu", v), r0, tbl[v].exp0);
    end

    for (int t = 0; t < 12; t++) begin
      int n = $urandom_range(1, 8);
      logic [PW-1:0] b = PW'($urandom);
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 9; k++) begin
          int xv = int'($urandom_range(0, 131071)) - 65536;
          int wv = (t < 10) ? int'($urandom_range(0, 16383)) - 8192 : int'($urandom_range(0, 65535));
          g_win[i][k*DW +: DW] = xv[DW-1:0];
          g_wts[i][k*PW +: PW] = wv[PW-1:0];
        end
      e1 = model(n, b, 1'b1);
      e0 = model(n, b, 1'b0);
      run_pixel(n, b, 1'b1, $urandom_range(0, 3), r1, r0);
      check($sformatf("rand%0d_relu", t),   r1, e1);
      check($sformatf("rand%0d_norelu", t), r0, e0);
    end

    fill_uniform(32, 1'b0, 22'd16384, 16'd16384);
    @(negedge clk);
    start = 1'b1; n_ch = 7'd32; bias = 16'd0;
    @(negedge clk);
    start = 1'b0;
    takes = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      window = g_win[i];
      weights = g_wts[i];
      if (in_ready1) takes++;
      @(negedge clk);
    end
    check("midop_beats_taken", takes, 10);
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    check_idle_outputs("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid1 || busy1) stray++;
    end
    check("post_reset_quiet", stray, 0);
    fill_uniform(1, 1'b0, 22'd16384, 16'd16384);
    run_pixel(1, 16'd0, 1'b0, 0, r1, r0);
    check("post_reset_identity", r1, 147456);
    check("post_reset_identity_nr", r0, 147456);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
